mem_port_arbiter: RTL and testbench

//  Shares one single-port synchronous word RAM between the core's instruction-fetch port (read-only)
//  and data port (read/write), replacing the separate instruction and data memory arrays.

---
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous word RAM between the fetch port (read-only) and the data port.
// Data has priority; fetch is forced through after MAX_DBURST consecutive data grants.
module mem_port_arbiter #(
    parameter int AW         = 6,
    parameter int MAX_DBURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [31:0]   i_addr,
    output logic [31:0]   i_rdata,
    output logic          i_valid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    output logic [31:0]   d_rdata,
    output logic          d_valid,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata
);
    // state   | meaning
    // S_IDLE  | sample requests, pick a winner, load the RAM command registers
    // S_ISSUE | RAM command presented (m_en high for this cycle only)
    // S_WAIT  | RAM read data returns; captured into the winner's rdata register
    // S_DONE  | winner's valid pulse
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam int            CW      = $clog2(MAX_DBURST + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DBURST);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sel_data_q, sel_data_d;
    logic            op_we_q, op_we_d;
    logic            m_en_q, m_en_d;
    logic            m_we_q, m_we_d;
    logic [AW-1:0]   m_addr_q, m_addr_d;
    logic [31:0]     m_wdata_q, m_wdata_d;
    logic [31:0]     i_rdata_q, i_rdata_d;
    logic [31:0]     d_rdata_q, d_rdata_d;
    logic            i_valid_q, i_valid_d;
    logic            d_valid_q, d_valid_d;

    // Byte offset and bits above the RAM size are dropped, so addresses wrap.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:AW+2], i_addr[1:0], d_addr[31:AW+2], d_addr[1:0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_data_d = sel_data_q;
        op_we_d    = op_we_q;
        m_en_d     = 1'b0;
        m_we_d     = 1'b0;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        i_valid_d  = 1'b0;
        d_valid_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (d_req && (!i_req || cnt_q < CNT_MAX)) begin
                    sel_data_d = 1'b1;
                    op_we_d    = d_we;
                    m_en_d     = 1'b1;
                    m_we_d     = d_we;
                    m_addr_d   = d_addr[AW+1:2];
                    m_wdata_d  = d_wdata;
                    if (i_req)
                        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
                    else
                        cnt_d = '0;
                    state_d    = S_ISSUE;
                end else if (i_req) begin
                    sel_data_d = 1'b0;
                    op_we_d    = 1'b0;
                    m_en_d     = 1'b1;
                    m_addr_d   = i_addr[AW+1:2];
                    cnt_d      = '0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (sel_data_q) begin
                    if (!op_we_q)
                        d_rdata_d = m_rdata;
                    d_valid_d = 1'b1;
                end else begin
                    i_rdata_d = m_rdata;
                    i_valid_d = 1'b1;
                end
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sel_data_q <= 1'b0;
            op_we_q    <= 1'b0;
            m_en_q     <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
            i_valid_q  <= 1'b0;
            d_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_data_q <= sel_data_d;
            op_we_q    <= op_we_d;
            m_en_q     <= m_en_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            i_valid_q  <= i_valid_d;
            d_valid_q  <= d_valid_d;
        end
    end

    assign m_en    = m_en_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_valid = i_valid_q;
    assign d_valid = d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, checked against a
// transaction-level schedule model (grant decision, access timing, shadow memory contents).
module tb_mem_port_arbiter;
    localparam int AW   = 6;
    localparam int MAXD = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_req = 1'b0;
    logic [31:0]   i_addr = '0;
    logic [31:0]   i_rdata;
    logic          i_valid;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [31:0]   d_addr = '0;
    logic [31:0]   d_wdata = '0;
    logic [31:0]   d_rdata;
    logic          d_valid;
    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [31:0]   m_rdata = '0;

    mem_port_arbiter #(.AW(AW), .MAX_DBURST(MAXD)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // Environment RAM: synchronous read, data one cycle after the enable; preload port for setup.
    logic [31:0]   ram [64];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [31:0]   pl_data = '0;
    always @(posedge clk) begin
        if (pl_en)
            ram[pl_addr] <= pl_data;
        else if (m_en) begin
            if (m_we) ram[m_addr] <= m_wdata;
            m_rdata <= ram[m_addr];
        end
    end

    int checks = 0;
    int failures = 0;

    // Reference model state
    int          cyc = 0;
    int          next_free = 0;
    int          issue_cyc = -1;
    int          valid_cyc = -1;
    int          mcnt = 0;
    bit          p_data = 1'b0;
    bit          p_we = 1'b0;
    int          p_addr = 0;
    logic [31:0] p_wdata = '0;
    logic [31:0] p_rdata = '0;
    logic [31:0] exp_i_rdata = '0;
    logic [31:0] exp_d_rdata = '0;
    logic [31:0] exp_mem [64];
    bit          obs_log [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    // Decide what the arbiter does with the inputs presented in the current cycle.
    task automatic model_sample();
        bit granted;
        granted = 1'b0;
        if (reset) begin
            next_free = cyc + 1;
        end else if (cyc == next_free) begin
            if (d_req && (!i_req || mcnt < MAXD)) begin
                granted = 1'b1;
                p_data  = 1'b1;
                p_we    = d_we;
                p_addr  = int'((d_addr / 32'd4) % 32'd64);
                p_wdata = d_wdata;
                if (d_we) exp_mem[p_addr] = d_wdata;
                else      p_rdata = exp_mem[p_addr];
                if (i_req) mcnt = (mcnt + 1 > MAXD) ? MAXD : mcnt + 1;
                else       mcnt = 0;
            end else if (i_req) begin
                granted = 1'b1;
                p_data  = 1'b0;
                p_we    = 1'b0;
                p_addr  = int'((i_addr / 32'd4) % 32'd64);
                p_rdata = exp_mem[p_addr];
                mcnt    = 0;
            end
            if (granted) begin
                issue_cyc = cyc + 1;
                valid_cyc = cyc + 3;
                next_free = cyc + 4;
            end else begin
                next_free = cyc + 1;
            end
        end
    endtask

    task automatic cycle();
        model_sample();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc == valid_cyc && !p_we) begin
            if (p_data) exp_d_rdata = p_rdata;
            else        exp_i_rdata = p_rdata;
        end
        chk("m_en", 32'(m_en), 32'(cyc == issue_cyc));
        if (cyc == issue_cyc) begin
            chk("m_addr", 32'(m_addr), 32'(p_addr));
            chk("m_we", 32'(m_we), 32'(p_we));
            if (p_we) chk("m_wdata", m_wdata, p_wdata);
        end else begin
            chk("m_we_idle", 32'(m_we), 32'd0);
        end
        chk("i_valid", 32'(i_valid), 32'(cyc == valid_cyc && !p_data));
        chk("d_valid", 32'(d_valid), 32'(cyc == valid_cyc && p_data));
        chk("one_valid", 32'(i_valid & d_valid), 32'd0);
        chk("i_rdata", i_rdata, exp_i_rdata);
        chk("d_rdata", d_rdata, exp_d_rdata);
        if (d_valid === 1'b1)      obs_log.push_back(1'b1);
        else if (i_valid === 1'b1) obs_log.push_back(1'b0);
    endtask

    task automatic wait_valid(input bit data, output int at);
        at = -1;
        for (int k = 0; k < 16; k++) begin
            cycle();
            if ((data && d_valid === 1'b1) || (!data && i_valid === 1'b1)) begin
                at = cyc;
                break;
            end
        end
        if (data) chk("d_valid_timeout", 32'(at != -1), 32'd1);
        else      chk("i_valid_timeout", 32'(at != -1), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m_en"},    32'(m_en), 32'd0);
        chk({tag, "_m_we"},    32'(m_we), 32'd0);
        chk({tag, "_m_addr"},  32'(m_addr), 32'd0);
        chk({tag, "_m_wdata"}, m_wdata, 32'd0);
        chk({tag, "_i_valid"}, 32'(i_valid), 32'd0);
        chk({tag, "_d_valid"}, 32'(d_valid), 32'd0);
        chk({tag, "_i_rdata"}, i_rdata, 32'd0);
        chk({tag, "_d_rdata"}, d_rdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          start, at, at2;
        logic [31:0] v, saved;
        bit          pat [6];
        pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        // Preload RAM and shadow memory while reset is held
        for (int i = 0; i < 64; i++) begin
            v = (i == 2) ? 32'h0050_0113 : $urandom;
            pl_en = 1'b1; pl_addr = AW'(i); pl_data = v; exp_mem[i] = v;
            @(posedge clk); #1;
        end
        pl_en = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("reset");
        reset = 1'b0;
        cyc = 0; next_free = 0;

        // 1: single fetch, latency
        i_req = 1'b1; i_addr = 32'h8; start = cyc;
        cycle();
        chk("t1_m_addr", 32'(m_addr), 32'd2);
        wait_valid(1'b0, at);
        chk("t1_latency", at, start + 3);
        chk("t1_rdata", i_rdata, 32'h0050_0113);
        i_req = 1'b0; cycle();

        // 2: simultaneous requests, data first
        i_req = 1'b1; i_addr = 32'h4;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; start = cyc;
        cycle();
        chk("t2_m_addr", 32'(m_addr), 32'd8);
        wait_valid(1'b1, at);
        chk("t2_d_latency", at, start + 3);
        d_req = 1'b0;
        wait_valid(1'b0, at2);
        chk("t2_i_latency", at2, start + 7);
        i_req = 1'b0; cycle();

        // 3: data burst with fetch pending
        obs_log.delete();
        d_req = 1'b1; d_we = 1'b0; d_addr = $urandom; i_req = 1'b1; i_addr = $urandom;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (d_valid === 1'b1) d_addr = $urandom;
            if (obs_log.size() >= 6) break;
        end
        chk("t3_events", 32'(obs_log.size() >= 6), 32'd1);
        for (int k = 0; k < 6; k++)
            if (k < obs_log.size()) chk($sformatf("t3_seq%0d", k), 32'(obs_log[k]), 32'(pat[k]));
        i_req = 1'b0; d_req = 1'b0; cycle();

        // 4: write then read back
        saved = exp_d_rdata;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF; start = cyc;
        cycle();
        chk("t4_m_we", 32'(m_we), 32'd1);
        chk("t4_m_addr", 32'(m_addr), 32'd4);
        wait_valid(1'b1, at);
        chk("t4_latency", at, start + 3);
        chk("t4_rdata_kept", d_rdata, saved);
        d_req = 1'b0; cycle();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        wait_valid(1'b1, at);
        chk("t4_readback", d_rdata, 32'hDEAD_BEEF);
        d_req = 1'b0; cycle();

        // 6: address wrap and byte offset
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
        cycle();
        chk("t6_wrap", 32'(m_addr), 32'd1);
        wait_valid(1'b1, at);
        d_req = 1'b0; cycle();
        d_req = 1'b1; d_addr = 32'h13;
        cycle();
        chk("t6_offset", 32'(m_addr), 32'd4);
        wait_valid(1'b1, at);
        d_req = 1'b0; cycle();

        // 5: reset during WAIT of a fetch
        i_req = 1'b1; i_addr = $urandom;
        cycle();
        cycle();
        reset = 1'b1;
        #1;
        chk_all_zero("t5_async");
        issue_cyc = -1; valid_cyc = -1; mcnt = 0;
        exp_i_rdata = '0; exp_d_rdata = '0;
        i_req = 1'b0;
        cycle();
        reset = 1'b0;
        i_req = 1'b1; i_addr = 32'h8; start = cyc;
        cycle();
        wait_valid(1'b0, at);
        chk("t5_after_reset", at, start + 3);
        chk("t5_rdata", i_rdata, 32'h0050_0113);
        i_req = 1'b0; cycle();

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            if (i_req && i_valid === 1'b1) i_req = 1'b0;
            if (d_req && d_valid === 1'b1) d_req = 1'b0;
            if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1'b1; i_addr = $urandom;
            end
            if (!d_req && $urandom_range(0, 1) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
                d_addr = $urandom; d_wdata = $urandom;
            end
            cycle();
        end
        i_req = 1'b0; d_req = 1'b0;
        repeat (8) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
